// File: rtl/sram_arb_pkg.sv
// Shared widths and FSM encoding for the SRAM arbiter slice.
package sram_arb_pkg;

   localparam int RAM_AW = 15;
   localparam int RAM_DW = 16;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_RESP = 1'b1
   } arb_state_t;

endpackage

// File: rtl/sram_arb_wait_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sram_arb_wait_cnt #(
   parameter int W     = 16,
   parameter int LIMIT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] count_reg, count_next;

   always_comb begin
      count_next = count_reg;
      if (clr)
         count_next = '0;
      else if (inc && (count_reg != LIM))
         count_next = count_reg + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

   assign count = count_reg;

endmodule

// File: rtl/sram_arbiter.sv
// CPU-priority arbiter for the single-port SRAM with a DMA req/gnt port and 1-cycle read return.
// Optional wait statistics (stat_clr/stat_wait) are built when ARB_WAIT_STATS_EN is defined.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AW           = RAM_AW,
   parameter int DW           = RAM_DW,
   parameter int STARVE_LIMIT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_sel,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_wr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic          starve,
`ifdef ARB_WAIT_STATS_EN
   input  logic          stat_clr,
   output logic [15:0]   stat_wait,
`endif
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   input  logic [DW-1:0] ram_dout
);

   arb_state_t    state_reg, state_next;
   logic [AW-1:0] addr_hold_reg;
   logic [DW-1:0] din_hold_reg;
   logic [DW-1:0] rdata_hold_reg;
   logic          starve_reg, starve_next;
   logic          dma_wait;
   logic [15:0]   starve_cnt;

   assign dma_gnt   = dma_req & ~cpu_sel;
   assign dma_wait  = dma_req & ~dma_gnt;
   assign cpu_rdata = ram_dout;

   // With no owner the address/data lines park on the last DMA values.
   always_comb begin
      ram_addr = addr_hold_reg;
      ram_din  = din_hold_reg;
      ram_we   = 1'b0;
      if (cpu_sel) begin
         ram_addr = cpu_addr;
         ram_din  = cpu_wdata;
         ram_we   = cpu_wr;
      end else if (dma_gnt) begin
         ram_addr = dma_addr;
         ram_din  = dma_wdata;
         ram_we   = dma_we;
      end
   end

   always_comb begin
      state_next = IDLE;
      case (state_reg)
         IDLE, RD_RESP: if (dma_gnt && !dma_we) state_next = RD_RESP;
         default:       state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         addr_hold_reg  <= '0;
         din_hold_reg   <= '0;
         rdata_hold_reg <= '0;
         starve_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (dma_gnt) begin
            addr_hold_reg <= dma_addr;
            din_hold_reg  <= dma_wdata;
         end
         if (state_reg == RD_RESP)
            rdata_hold_reg <= ram_dout;
         starve_reg <= starve_next;
      end
   end

   // douta already carries the DMA word during RD_RESP; outside it the captured word is held.
   assign dma_rvalid = (state_reg == RD_RESP);
   assign dma_rdata  = dma_rvalid ? ram_dout : rdata_hold_reg;

   sram_arb_wait_cnt #(
      .W     (16),
      .LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (dma_gnt | ~dma_req),
      .inc   (dma_wait),
      .count (starve_cnt)
   );

   // Set on the edge at which the wait count reaches the limit.
   always_comb begin
      starve_next = starve_reg;
      if (dma_gnt)
         starve_next = 1'b0;
      else if (dma_wait && (starve_cnt >= 16'(STARVE_LIMIT - 1)))
         starve_next = 1'b1;
   end

   assign starve = starve_reg;

`ifdef ARB_WAIT_STATS_EN
   sram_arb_wait_cnt #(
      .W     (16),
      .LIMIT (16'hFFFF)
   ) u_stat_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (stat_clr),
      .inc   (dma_wait),
      .count (stat_wait)
   );
`endif

endmodule
